// File: rtl/pwm_duty_decoder.sv
// PWM receive-side decoder: synchronizes a PWM input, measures period and high
// time between rising edges, recovers the duty code and flags a stuck input.
module pwm_duty_decoder #(
    parameter int W       = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [W-1:0]     duty_out,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             locked,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    localparam logic [CNT_W-1:0] NOMINAL = CNT_W'(2 ** W);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        WAIT_EDGE,
        MEASURE,
        STUCK
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             pwm_meta;
    logic             pwm_s;
    logic             pwm_d;
    logic             rise;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             timeout;
    logic             capture;
    logic             enter_stuck;
    logic             track_stuck;

    assign rise    = pwm_s & ~pwm_d;
    assign timeout = (period_cnt == TMO);

    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample the pre-edge values and simulation order cannot change behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_meta <= 1'b0;
            pwm_s    <= 1'b0;
            pwm_d    <= 1'b0;
        end else begin
            pwm_meta <= pwm_in;
            pwm_s    <= pwm_meta;
            pwm_d    <= pwm_s;
        end
    end

    // Both counters restart at 1 on the rise cycle and saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (rise) begin
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(1);
        end else begin
            if (period_cnt != CNT_MAX) begin
                period_cnt <= period_cnt + CNT_W'(1);
            end
            if (pwm_s && (high_cnt != CNT_MAX)) begin
                high_cnt <= high_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT_EDGE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: all combinational outputs get a default before the case so no
    // path leaves them unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        enter_stuck = 1'b0;
        case (state)
            WAIT_EDGE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end else if (timeout) begin
                    state_nxt   = STUCK;
                    enter_stuck = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    capture = 1'b1;
                end else if (timeout) begin
                    state_nxt   = STUCK;
                    enter_stuck = 1'b1;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end
            end
            default: state_nxt = WAIT_EDGE;
        endcase
    end

    // The rise that leaves STUCK is only a reference; flags hold until the next capture.
    assign track_stuck = enter_stuck | ((state == STUCK) & ~rise);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_out   <= '0;
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
        end else begin
            valid <= capture;
            if (capture) begin
                period_out <= period_cnt;
                high_out   <= high_cnt;
                locked     <= (period_cnt == NOMINAL);
                if (period_cnt == NOMINAL) begin
                    duty_out <= high_cnt[W-1:0];
                end
                stuck_hi <= 1'b0;
                stuck_lo <= 1'b0;
            end else if (track_stuck) begin
                stuck_hi <= pwm_s;
                stuck_lo <= ~pwm_s;
                locked   <= 1'b0;
                if (enter_stuck && !pwm_s) begin
                    duty_out <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: event-level model compared every
// cycle, plus directed literal expectations per scenario.
module tb_pwm_duty_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pwm_in = 1'b0;
    logic [3:0]  duty_out;
    logic [15:0] period_out;
    logic [15:0] high_out;
    logic        valid;
    logic        locked;
    logic        stuck_hi;
    logic        stuck_lo;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;

    pwm_duty_decoder #(.W(4), .CNT_W(16), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .locked     (locked),
        .stuck_hi   (stuck_hi),
        .stuck_lo   (stuck_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: edge timestamps in the synchronized domain (input delayed 2 clks).
    int       m_t;
    int       m_ref_t;
    int       m_fall_t;
    bit       h1, h2, h3;
    bit       have_ref;
    bit       in_stuck;
    bit [3:0] e_duty;
    int       e_period;
    int       e_high;
    bit       e_valid;
    bit       e_locked;
    bit       e_shi;
    bit       e_slo;

    task automatic model_clear();
        m_t = 0; m_ref_t = 1; m_fall_t = 0;
        h1 = 0; h2 = 0; h3 = 0;
        have_ref = 0; in_stuck = 0;
        e_duty = 0; e_period = 0; e_high = 0;
        e_valid = 0; e_locked = 0; e_shi = 0; e_slo = 0;
    endtask

    task automatic model_step();
        bit ps, pd;
        int age;
        m_t++;
        ps = h2;
        pd = h3;
        h3 = h2; h2 = h1; h1 = pwm_in;
        age = m_t - m_ref_t;
        if (age > 65535) age = 65535;
        e_valid = 0;
        if (!ps && pd) m_fall_t = m_t;
        if (ps && !pd) begin
            if (have_ref && !in_stuck) begin
                e_period = age;
                e_high   = (m_fall_t > m_ref_t) ? (m_fall_t - m_ref_t) : age;
                e_valid  = 1;
                e_locked = (age == 16);
                if (e_locked) e_duty = 4'(e_high % 16);
                e_shi = 0;
                e_slo = 0;
            end
            have_ref = 1;
            in_stuck = 0;
            m_ref_t  = m_t;
        end else if (in_stuck || age == 64) begin
            if (!in_stuck && !ps) e_duty = 0;
            in_stuck = 1;
            e_shi    = ps;
            e_slo    = !ps;
            e_locked = 0;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_clear();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("duty_out",   int'(duty_out),   int'(e_duty));
            check("period_out", int'(period_out), e_period);
            check("high_out",   int'(high_out),   e_high);
            check("valid",      int'(valid),      int'(e_valid));
            check("locked",     int'(locked),     int'(e_locked));
            check("stuck_hi",   int'(stuck_hi),   int'(e_shi));
            check("stuck_lo",   int'(stuck_lo),   int'(e_slo));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (valid === 1'b1) valid_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input int period, input int high, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < period; i++) begin
                @(negedge clk);
                pwm_in = (i < high);
            end
        end
    endtask

    task automatic hold(input logic level, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pwm_in = level;
        end
    endtask

    initial begin
        int v0;
        repeat (5) @(negedge clk);
        check("rst_duty",   int'(duty_out),   0);
        check("rst_period", int'(period_out), 0);
        check("rst_valid",  int'(valid),      0);
        rst = 1'b1;

        // T1: 16/7
        v0 = valid_cnt;
        drive(16, 7, 4);
        check("t1_valids", valid_cnt - v0, 3);
        check("t1_duty",   int'(duty_out),   7);
        check("t1_period", int'(period_out), 16);
        check("t1_high",   int'(high_out),   7);
        check("t1_locked", int'(locked),     1);

        // T2: 16/2 then 16/12
        drive(16, 2, 3);
        check("t2_duty2",  int'(duty_out), 2);
        check("t2_high2",  int'(high_out), 2);
        check("t2_locked", int'(locked),   1);
        drive(16, 12, 3);
        check("t2_duty12", int'(duty_out), 12);
        check("t2_high12", int'(high_out), 12);

        // T3: stuck low, then recover
        v0 = valid_cnt;
        hold(1'b0, 75);
        check("t3_valids",   valid_cnt - v0,  0);
        check("t3_stuck_lo", int'(stuck_lo),  1);
        check("t3_stuck_hi", int'(stuck_hi),  0);
        check("t3_duty",     int'(duty_out),  0);
        check("t3_locked",   int'(locked),    0);
        v0 = valid_cnt;
        drive(16, 7, 4);
        check("t3r_valids",   valid_cnt - v0, 3);
        check("t3r_stuck_lo", int'(stuck_lo), 0);
        check("t3r_duty",     int'(duty_out), 7);
        check("t3r_locked",   int'(locked),   1);

        // T4: stuck high keeps duty
        hold(1'b1, 75);
        check("t4_stuck_hi", int'(stuck_hi), 1);
        check("t4_stuck_lo", int'(stuck_lo), 0);
        check("t4_duty",     int'(duty_out), 7);
        check("t4_locked",   int'(locked),   0);

        // T5: off-nominal period 20/5
        v0 = valid_cnt;
        drive(20, 5, 3);
        check("t5_valids",   valid_cnt - v0,   1);
        check("t5_period",   int'(period_out), 20);
        check("t5_high",     int'(high_out),   5);
        check("t5_locked",   int'(locked),     0);
        check("t5_duty",     int'(duty_out),   7);
        check("t5_stuck_hi", int'(stuck_hi),   0);

        // T6: async reset mid-period
        drive(16, 7, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pwm_in = (i < 7);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_duty",   int'(duty_out),   0);
        check("t6_period", int'(period_out), 0);
        check("t6_high",   int'(high_out),   0);
        check("t6_locked", int'(locked),     0);
        check("t6_valid",  int'(valid),      0);
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        v0 = valid_cnt;
        drive(16, 7, 1);
        check("t6_first_rise_valids", valid_cnt - v0, 0);
        check("t6_first_rise_duty",   int'(duty_out), 0);
        drive(16, 7, 1);
        check("t6_second_rise_valids", valid_cnt - v0, 1);
        check("t6_duty7",   int'(duty_out),   7);
        check("t6_period16", int'(period_out), 16);
        check("t6_locked1", int'(locked),     1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
